// File: rtl/dmem_pkg.sv
// dmem_pkg: constants shared by the data-memory arbiter and its grant logic.
//   WORD_IDX_LSB/MSB : byte-address bits the 1024-word memory decodes
//   PORT_PIPE/LOAD   : index of each requester in grant vectors
//   CNT_W            : width of the starvation counter
package dmem_pkg;

    localparam int WORD_IDX_LSB = 2;
    localparam int WORD_IDX_MSB = 11;
    localparam int PORT_PIPE    = 0;
    localparam int PORT_LOAD    = 1;
    localparam int CNT_W        = 4;

    // A word access is misaligned when either byte-offset bit is set.
    function automatic logic misaligned(input logic [WORD_IDX_LSB-1:0] lsb);
        return |lsb;
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: purely combinational grant decision for the two requesters.
// Ports:
//   p0_req     in   pipeline request
//   p1_req     in   loader request
//   starve_cnt in   consecutive contested port-0 grants so far
//   grant0     out  port 0 wins this cycle
//   grant1     out  port 1 wins this cycle (never together with grant0)
module dmem_arb_pick
    import dmem_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic             p0_req,
    input  logic             p1_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant0,
    output logic             grant1
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    // Port 0 wins uncontested, or contested until the loader has waited
    // STARVE_MAX cycles; port 1 takes whatever port 0 does not.
    always_comb begin
        grant0 = p0_req & (~p1_req | (starve_cnt < CNT_MAX));
        grant1 = p1_req & ~grant0;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port 1024x32 data memory between the
// pipeline MEM stage (port 0) and the program/debug loader (port 1).
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   p0_req/we/addr/wdata            pipeline request
//   p0_stall                        combinational: request not granted
//   p0_ack/rdata/err                registered response, one cycle after grant
//   p1_req/we/addr/wdata            loader request
//   p1_gnt                          combinational grant to loader
//   p1_ack/rdata/err                registered response, one cycle after grant
//   mem_addr/wdata/we, mem_rdata    memory side (async read, write on clk)
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_stall,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [1:0]        grant;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              p0_ack_q, p0_ack_d, p1_ack_q, p1_ack_d;
    logic              p0_err_q, p0_err_d, p1_err_q, p1_err_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        r = a;
        r[WORD_IDX_LSB-1:0] = '0;
        return r;
    endfunction

    dmem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .p0_req     (p0_req),
        .p1_req     (p1_req),
        .starve_cnt (starve_cnt_q),
        .grant0     (grant[PORT_PIPE]),
        .grant1     (grant[PORT_LOAD])
    );

    assign p0_stall = p0_req & ~grant[PORT_PIPE];
    assign p1_gnt   = grant[PORT_LOAD];

    // Memory-side mux: idle cycles drive zeros so the bus is quiet.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (grant[PORT_PIPE]) begin
            mem_addr  = word_align(p0_addr);
            mem_wdata = p0_wdata;
            mem_we    = p0_we;
        end else if (grant[PORT_LOAD]) begin
            mem_addr  = word_align(p1_addr);
            mem_wdata = p1_wdata;
            mem_we    = p1_we;
        end
    end

    // Counts contested port-0 wins; any cycle the loader is not waiting
    // (not requesting, or just granted) starts the count over.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!p1_req || grant[PORT_LOAD]) begin
            starve_cnt_d = '0;
        end else if (grant[PORT_PIPE] && (starve_cnt_q < CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Responses: ack/err follow the grant; rdata only reloads on a granted read.
    always_comb begin
        p0_ack_d   = grant[PORT_PIPE];
        p0_err_d   = grant[PORT_PIPE] & misaligned(p0_addr[WORD_IDX_LSB-1:0]);
        p0_rdata_d = (grant[PORT_PIPE] && !p0_we) ? mem_rdata : p0_rdata_q;
        p1_ack_d   = grant[PORT_LOAD];
        p1_err_d   = grant[PORT_LOAD] & misaligned(p1_addr[WORD_IDX_LSB-1:0]);
        p1_rdata_d = (grant[PORT_LOAD] && !p1_we) ? mem_rdata : p1_rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            p0_ack_q     <= 1'b0;
            p0_err_q     <= 1'b0;
            p0_rdata_q   <= '0;
            p1_ack_q     <= 1'b0;
            p1_err_q     <= 1'b0;
            p1_rdata_q   <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            p0_ack_q     <= p0_ack_d;
            p0_err_q     <= p0_err_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_ack_q     <= p1_ack_d;
            p1_err_q     <= p1_err_d;
            p1_rdata_q   <= p1_rdata_d;
        end
    end

    assign p0_ack   = p0_ack_q;
    assign p0_err   = p0_err_q;
    assign p0_rdata = p0_rdata_q;
    assign p1_ack   = p1_ack_q;
    assign p1_err   = p1_err_q;
    assign p1_rdata = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_stall, p0_ack, p0_err, p1_gnt, p1_ack, p1_err, mem_we;
    logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;

    // Memory the arbiter fronts: asynchronous read, write on rising edge.
    logic [31:0] mem [0:1023];
    always @(posedge clk) if (mem_we) mem[mem_addr[WORD_IDX_MSB:WORD_IDX_LSB]] <= mem_wdata;
    assign mem_rdata = mem[mem_addr[WORD_IDX_MSB:WORD_IDX_LSB]];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_stall(p0_stall), .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    int total  = 0;
    int passed = 0;

    // Reference model: shadow memory, count of loader wait cycles, expected responses.
    logic [31:0] ref_mem [0:1023];
    int          wait_cnt = 0;
    logic        e_ack0 = 0, e_err0 = 0, e_ack1 = 0, e_err1 = 0;
    logic [31:0] e_rd0 = 0, e_rd1 = 0;
    logic        seen_gnt1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One bus cycle; entered and left 1 time unit after a rising edge.
    task automatic step(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        bit g0, g1;
        logic [31:0] ea, ed;
        logic        ew;
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
        #1;
        // Loader wins once it has watched STARVE_MAX contested port-0 wins.
        g0 = r0 && (!r1 || wait_cnt < STARVE_MAX);
        g1 = r1 && !g0;
        ea = g0 ? (a0 & ~32'h3) : g1 ? (a1 & ~32'h3) : 32'h0;
        ed = g0 ? d0 : g1 ? d1 : 32'h0;
        ew = g0 ? w0 : g1 ? w1 : 1'b0;
        seen_gnt1 = p1_gnt;
        chk("p0_stall", p0_stall, r0 && !g0);
        chk("p1_gnt", p1_gnt, g1);
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ed);
        chk("mem_we", mem_we, ew);
        e_ack0 = g0; e_err0 = g0 && (a0 % 4 != 0);
        e_ack1 = g1; e_err1 = g1 && (a1 % 4 != 0);
        if (g0) begin
            if (w0) ref_mem[a0 / 4 % 1024] = d0; else e_rd0 = ref_mem[a0 / 4 % 1024];
        end
        if (g1) begin
            if (w1) ref_mem[a1 / 4 % 1024] = d1; else e_rd1 = ref_mem[a1 / 4 % 1024];
        end
        if (!r1 || g1) wait_cnt = 0;
        else if (g0 && wait_cnt < STARVE_MAX) wait_cnt++;
        @(posedge clk); #1;
        chk("p0_ack", p0_ack, e_ack0);
        chk("p0_err", p0_err, e_err0);
        chk("p0_rdata", p0_rdata, e_rd0);
        chk("p1_ack", p1_ack, e_ack1);
        chk("p1_err", p1_err, e_err1);
        chk("p1_rdata", p1_rdata, e_rd1);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
        #2;
        chk("rst_p0_ack", p0_ack, 0);
        chk("rst_p1_ack", p1_ack, 0);
        chk("rst_p0_err", p0_err, 0);
        chk("rst_p1_err", p1_err, 0);
        chk("rst_p0_rdata", p0_rdata, 0);
        chk("rst_p1_rdata", p1_rdata, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Give the words used below known contents.
        for (int w = 0; w < 16; w++) step(1, 1, w * 4, 32'h1000_0000 + w, 0, 0, 0, 0);

        // Solo port 0: write then read back.
        step(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
        step(1, 0, 32'h10, 0, 0, 0, 0, 0);
        chk("solo_rdata", p0_rdata, 32'hDEADBEEF);

        // Continuous contention: port 1 wins every fifth cycle.
        idle();
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 32'h4, 0, 1, 0, 32'h8, 0);
            chk("contend_gnt1", seen_gnt1, (i % 5) == 4);
        end

        // Cross-port hazard: loader reads a word port 0 wrote the cycle before.
        step(1, 1, 32'h20, 32'h12345678, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 32'h20, 0);
        chk("hazard_rdata", p1_rdata, 32'h12345678);

        // Misaligned loader read.
        step(1, 1, 32'h20, 32'hCAFEF00D, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 32'h23, 0);
        chk("misal_err", p1_err, 1);
        chk("misal_rdata", p1_rdata, 32'hCAFEF00D);

        // Abandon: loader request dropped while stalled, then full starve window again.
        step(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
        step(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
        step(1, 0, 32'h0, 0, 0, 0, 0, 0);
        chk("abandon_ack", p1_ack, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 32'hC, 0, 1, 0, 32'h8, 0);
            chk("abandon_restart", seen_gnt1, i == 4);
        end

        // Randomised traffic over the initialised words.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 32'($urandom_range(0, 63)), $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, 32'($urandom_range(0, 63)), $urandom);
        end

        // Reset mid-traffic: both ports just acked reads of nonzero words.
        step(1, 0, 32'h10, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 32'h0, 0);
        p0_req = 1; p0_we = 0; p0_addr = 32'h10;
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_p1_ack", p1_ack, 0);
        chk("mid_rst_p0_err", p0_err, 0);
        chk("mid_rst_p0_rdata", p0_rdata, 0);
        chk("mid_rst_p1_rdata", p1_rdata, 0);
        chk("mid_rst_stall", p0_stall, 0);
        p0_req = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_cnt = 0; e_ack0 = 0; e_err0 = 0; e_ack1 = 0; e_err1 = 0; e_rd0 = 0; e_rd1 = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 32'h10, 0, 1, 0, 32'h14, 0);
            chk("post_rst_gnt1", seen_gnt1, i == 4);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port, word-addressed data memory (1024 × 32, asynchronous read, write on rising clk) between the pipeline MEM stage (port 0) and the program/debug loader (port 1). It sits between the MEM stage and the data memory. It grants one access per cycle, stalls the losing requester, and returns registered read data with a one-cycle acknowledge. A bounded-starvation counter guarantees port-1 progress while the pipeline is busy.

## Interface
- ADDR_W, 32, byte-address width on both ports and the memory side
- DATA_W, 32, data width
- STARVE_MAX, 4, max consecutive contested port-0 grants before port 1 is forced to win; legal range 1..15
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- p0_req  in  1  pipeline access request, held until not stalled
- p0_we  in  1  1 = write, 0 = read
- p0_addr  in  ADDR_W  byte address
- p0_wdata  in  DATA_W  write data
- p0_stall  out  1  combinational; 1 = request not granted this cycle, hold the stage
- p0_ack  out  1  registered; pulses the cycle after a port-0 grant
- p0_rdata  out  DATA_W  registered read data, valid with p0_ack on reads
- p0_err  out  1  registered; with p0_ack, address was misaligned
- p1_req, p1_we, p1_addr, p1_wdata  in  1/1/ADDR_W/DATA_W  loader request, same semantics as port 0
- p1_gnt  out  1  combinational grant to port 1
- p1_ack, p1_rdata, p1_err  out  1/DATA_W/1  as for port 0
- mem_addr  out  ADDR_W  address to memory; the memory uses bits [11:2]
- mem_wdata  out  DATA_W  write data to memory
- mem_we  out  1  write strobe, high only in a granted write cycle
- mem_rdata  in  DATA_W  asynchronous memory read data

## Operation
- Grant decision is combinational from the current requests and the registered state (starve_cnt). At most one grant per cycle.
- Only p0_req high: grant port 0. Only p1_req high: grant port 1. Neither high: idle; mem_we = 0 and mem_addr/mem_wdata = 0.
- Both high (contested): grant port 0 while starve_cnt < STARVE_MAX; otherwise grant port 1.
- starve_cnt is 4 bits:
  - increments on each contested port-0 grant;
  - clears on any port-1 grant or on any cycle with p1_req low;
  - saturates at STARVE_MAX.
- p0_stall = p0_req & ~grant0. p1_gnt = grant1.
- The granted port drives mem_addr, with bits [1:0] forced to 0, and mem_wdata. mem_we = that port's we.
- Misaligned address (addr[1:0] ≠ 0): the access still proceeds on the aligned word, and err is raised with the ack.
- On the next edge after a grant: the port's ack = 1 and err is registered.
  - Read: rdata captures mem_rdata.
  - Write: rdata holds its previous value.
- The non-granted port's ack = 0 and its rdata is unchanged.

## Timing
- Reset values: p0_ack = p1_ack = 0, p0_err = p1_err = 0, p0_rdata = p1_rdata = 0, starve_cnt = 0.
- Combinational outputs follow their inputs during reset. A reset mid-access drops any pending ack and does not undo a write already committed.
- Grant latency is 0 cycles, combinational in the request cycle. Ack/rdata latency is 1 cycle.
- A write commits on the grant-cycle edge. A port-1 read following a port-0 write to the same word one cycle later returns the new data.
- Back-to-back grants to the same port give continuous acks; throughput is 1 access/cycle.
- A request dropped while stalled is abandoned with no ack.
- Worst-case port-1 wait under continuous contention is STARVE_MAX cycles; the grant occurs in cycle STARVE_MAX+1.

## Structure
- Shared package dmem_pkg holds the constants: WORD_IDX_LSB = 2, WORD_IDX_MSB = 11, and the port index encoding (PORT_PIPE = 0, PORT_LOAD = 1).
- One sub-module, dmem_arb_pick: purely combinational grant logic, with inputs p0_req, p1_req, starve_cnt and outputs grant0, grant1.
- The top level holds the counter, the mux, and the response registers.

## Test plan
- Reset: assert rst_n = 0 mid-traffic → all acks, errs and rdata read 0 immediately; starve_cnt = 0 after release.
- Solo port 0: write 0xDEADBEEF to 0x10, then read 0x10 → p0_stall = 0 throughout; read ack one cycle later with p0_rdata = 0xDEADBEEF.
- Contention, STARVE_MAX = 4: both requests held high continuously → grant sequence 0,0,0,0,1,0,0,0,0,1,…
  - p0_stall high exactly in the port-1 cycles.
  - p1_gnt low in the port-0 cycles.
- Cross-port hazard: port 0 writes 0x12345678 to 0x20; next cycle port 1 reads 0x20 → p1_rdata = 0x12345678.
- Misaligned: port 1 reads 0x23 after word 0x20 holds 0xCAFEF00D → mem_addr = 0x20, p1_err = 1, p1_rdata = 0xCAFEF00D.
- Abandon: p1_req raised and dropped while port 0 holds the grant → no p1_ack; starve_cnt clears.
